// File: rtl/fsm_access_guard_if.sv
// Purpose: bundles the sequence-FSM observation inputs, the consumer ack and
//          the guard's status/control outputs into one port.
// Ports:   fsm_state/finished/ack are driven by the environment (master);
//          grant/locked/force_init/alarm/viol/fail_cnt are driven by the guard (slave).
interface fsm_access_guard_if #(
  parameter int MAX_FAIL = 3
);
  localparam int CW = $clog2(MAX_FAIL + 1);

  logic [2:0]    fsm_state;
  logic          finished;
  logic          ack;
  logic          grant;
  logic          locked;
  logic          force_init;
  logic          alarm;
  logic          viol;
  logic [CW-1:0] fail_cnt;

  modport master (
    output fsm_state, finished, ack,
    input  grant, locked, force_init, alarm, viol, fail_cnt
  );

  modport slave (
    input  fsm_state, finished, ack,
    output grant, locked, force_init, alarm, viol, fail_cnt
  );
endinterface

// File: rtl/fsm_access_guard.sv
// Purpose: turns a completed FSM sequence into a time-limited grant, counts
//          aborted attempts and enforces a lockout after MAX_FAIL of them.
// Latency: every output is registered; an event sampled on an edge is visible
//          right after that edge. No backpressure: events are evaluated every cycle.
// Ports:   clk, rst (async, active-high); bus (slave modport): fsm_state,
//          finished, ack in; grant, locked, force_init, alarm, viol, fail_cnt out.
module fsm_access_guard #(
  parameter int MAX_FAIL      = 3,
  parameter int LOCK_CYCLES   = 16,
  parameter int GRANT_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst,
  fsm_access_guard_if.slave   bus
);

  localparam int CW   = $clog2(MAX_FAIL + 1);
  localparam int TMAX = (LOCK_CYCLES > GRANT_TIMEOUT) ? LOCK_CYCLES : GRANT_TIMEOUT;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] GRANT_LOAD = TW'(GRANT_TIMEOUT - 1);
  localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] FAIL_MAX   = CW'(MAX_FAIL);

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_S1   = 3'd2;
  localparam logic [2:0] ST_LAST = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    prev_state_q, prev_state_d;
  logic          fin_q, fin_d;
  logic          grant_q, grant_d;
  logic          locked_q, locked_d;
  logic          force_init_q, force_init_d;
  logic          alarm_q, alarm_d;
  logic          viol_q, viol_d;
  logic [CW-1:0] fail_cnt_q, fail_cnt_d;

  logic          succ, fail, ill;
  logic [CW-1:0] fail_cnt_inc;
  logic          fail_hits_max;
  logic          timer_zero;

  assign succ          = bus.finished & ~fin_q;
  assign fail          = (prev_state_q == ST_S1) && (bus.fsm_state == ST_INIT);
  assign ill           = bus.fsm_state > ST_LAST;
  // Saturating increment so the count can never wrap back to zero.
  assign fail_cnt_inc  = (fail_cnt_q == FAIL_MAX) ? fail_cnt_q : fail_cnt_q + 1'b1;
  assign fail_hits_max = (fail_cnt_inc == FAIL_MAX);
  assign timer_zero    = (timer_q == '0);

  // State register (plus all other registered state and outputs).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      prev_state_q <= ST_INIT;
      fin_q        <= 1'b0;
      grant_q      <= 1'b0;
      locked_q     <= 1'b0;
      force_init_q <= 1'b0;
      alarm_q      <= 1'b0;
      viol_q       <= 1'b0;
      fail_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      prev_state_q <= prev_state_d;
      fin_q        <= fin_d;
      grant_q      <= grant_d;
      locked_q     <= locked_d;
      force_init_q <= force_init_d;
      alarm_q      <= alarm_d;
      viol_q       <= viol_d;
      fail_cnt_q   <= fail_cnt_d;
    end
  end

  // Next-state logic. Priority ill > fail > succ.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ill)                       state_d = LOCKED;
        else if (fail && fail_hits_max) state_d = LOCKED;
        else if (!fail && succ)        state_d = GRANTED;
      end
      GRANTED: begin
        if (ill)                       state_d = LOCKED;
        else if (bus.ack || timer_zero) state_d = IDLE;
      end
      LOCKED: begin
        // An illegal state reloads the lockout, so it wins over expiry.
        if (!ill && timer_zero)        state_d = IDLE;
      end
      default:                         state_d = IDLE;
    endcase
  end

  // Output and datapath logic, all feeding registers.
  always_comb begin
    prev_state_d = bus.fsm_state;
    fin_d        = bus.finished;
    grant_d      = (state_d == GRANTED);
    locked_d     = (state_d == LOCKED);
    // Hold the FSM in INIT during lockout, and kick it once when a grant ends.
    force_init_d = (state_d == LOCKED) || (state_q == GRANTED && state_d == IDLE);
    alarm_d      = (state_q != LOCKED) && (state_d == LOCKED);
    viol_d       = (state_q == LOCKED) && (ill || succ);
    timer_d      = timer_q;
    fail_cnt_d   = fail_cnt_q;

    case (state_q)
      IDLE: begin
        if (state_d == GRANTED)     timer_d = GRANT_LOAD;
        else if (state_d == LOCKED) timer_d = LOCK_LOAD;
        else                        timer_d = '0;
        if (!ill && fail)           fail_cnt_d = fail_cnt_inc;
        else if (!ill && succ)      fail_cnt_d = '0;
      end
      GRANTED: begin
        if (state_d == LOCKED)      timer_d = LOCK_LOAD;
        else if (state_d == IDLE)   timer_d = '0;
        else                        timer_d = timer_q - 1'b1;
      end
      LOCKED: begin
        if (ill)                    timer_d = LOCK_LOAD;
        else if (timer_zero)        timer_d = '0;
        else                        timer_d = timer_q - 1'b1;
        if (state_d == IDLE)        fail_cnt_d = '0;
      end
      default: begin
        timer_d    = '0;
        fail_cnt_d = '0;
      end
    endcase
  end

  assign bus.grant      = grant_q;
  assign bus.locked     = locked_q;
  assign bus.force_init = force_init_q;
  assign bus.alarm      = alarm_q;
  assign bus.viol       = viol_q;
  assign bus.fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_fsm_access_guard.sv
module tb_fsm_access_guard;

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_S0   = 3'd1;
  localparam logic [2:0] ST_S1   = 3'd2;
  localparam logic [2:0] ST_S2   = 3'd3;
  localparam logic [2:0] ST_S3   = 3'd4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fsm_access_guard_if #(.MAX_FAIL(3)) bus ();

  fsm_access_guard #(
    .MAX_FAIL(3),
    .LOCK_CYCLES(16),
    .GRANT_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [6:0] v;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Expected vector layout: {grant, locked, force_init, alarm, viol, fail_cnt[1:0]}
  function automatic logic [6:0] ex(input bit g, input bit l, input bit f,
                                    input bit a, input bit v, input int c);
    logic [1:0] cc;
    cc = c[1:0];
    return {g, l, f, a, v, cc};
  endfunction

  function automatic logic [6:0] act();
    return {bus.grant, bus.locked, bus.force_init, bus.alarm, bus.viol, bus.fail_cnt};
  endfunction

  // Monitor: outputs are presented every cycle, so each queued expectation is
  // compared against the outputs seen one negedge after it was issued.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [6:0] a;
    if (!rst && sb.size() > 0) begin
      e = sb.pop_front();
      a = act();
      checks++;
      if (a !== e.v) begin
        errors++;
        $display("FAIL %s: got {g,l,fi,al,vi,cnt}=%b required=%b", e.name, a, e.v);
      end
    end
  end

  task automatic step(input logic [2:0] st, input bit fin, input bit ak,
                      input logic [6:0] e, input string nm);
    exp_t item;
    @(negedge clk);
    #1;
    bus.fsm_state = st;
    bus.finished  = fin;
    bus.ack       = ak;
    item.v    = e;
    item.name = nm;
    sb.push_back(item);
  endtask

  // Assert reset mid-cycle and require outputs to clear before any clock edge.
  task automatic rst_check(input string nm);
    logic [6:0] a;
    @(negedge clk);
    #2;
    rst           = 1'b1;
    bus.fsm_state = ST_INIT;
    bus.finished  = 1'b0;
    bus.ack       = 1'b0;
    #1;
    a = act();
    checks++;
    if (a !== 7'b0) begin
      errors++;
      $display("FAIL %s: got {g,l,fi,al,vi,cnt}=%b required=%b", nm, a, 7'b0);
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : stim
    logic [6:0] a;
    rst           = 1'b1;
    bus.fsm_state = ST_INIT;
    bus.finished  = 1'b0;
    bus.ack       = 1'b0;
    @(negedge clk);
    #1;
    a = act();
    checks++;
    if (a !== 7'b0) begin
      errors++;
      $display("FAIL reset_state: got %b required %b", a, 7'b0);
    end
    rst = 1'b0;

    // 1: walk to S3, grant, ack in third grant cycle
    step(ST_INIT, 1'b0, 1'b0, ex(0,0,0,0,0,0), "t1_init");
    step(ST_S0,   1'b0, 1'b0, ex(0,0,0,0,0,0), "t1_s0");
    step(ST_S1,   1'b0, 1'b0, ex(0,0,0,0,0,0), "t1_s1");
    step(ST_S2,   1'b0, 1'b0, ex(0,0,0,0,0,0), "t1_s2");
    step(ST_S3,   1'b1, 1'b0, ex(1,0,0,0,0,0), "t1_grant");
    step(ST_S3,   1'b1, 1'b0, ex(1,0,0,0,0,0), "t1_grant2");
    step(ST_INIT, 1'b0, 1'b0, ex(1,0,0,0,0,0), "t1_grant3");
    step(ST_INIT, 1'b0, 1'b1, ex(0,0,1,0,0,0), "t1_ack");
    step(ST_INIT, 1'b0, 1'b0, ex(0,0,0,0,0,0), "t1_idle");

    // 2: grant without ack lasts exactly 8 cycles
    step(ST_S3, 1'b1, 1'b0, ex(1,0,0,0,0,0), "t2_grant");
    for (int i = 0; i < 7; i++) step(ST_INIT, 1'b0, 1'b0, ex(1,0,0,0,0,0), "t2_hold");
    step(ST_INIT, 1'b0, 1'b0, ex(0,0,1,0,0,0), "t2_timeout");
    step(ST_INIT, 1'b0, 1'b0, ex(0,0,0,0,0,0), "t2_idle");

    // 3: three aborts lock for 16 cycles
    step(ST_S1,   1'b0, 1'b0, ex(0,0,0,0,0,0), "t3_s1a");
    step(ST_INIT, 1'b0, 1'b0, ex(0,0,0,0,0,1), "t3_abort1");
    step(ST_S1,   1'b0, 1'b0, ex(0,0,0,0,0,1), "t3_s1b");
    step(ST_INIT, 1'b0, 1'b0, ex(0,0,0,0,0,2), "t3_abort2");
    step(ST_S1,   1'b0, 1'b0, ex(0,0,0,0,0,2), "t3_s1c");
    step(ST_INIT, 1'b0, 1'b0, ex(0,1,1,1,0,3), "t3_lock");
    for (int i = 0; i < 15; i++) step(ST_INIT, 1'b0, 1'b0, ex(0,1,1,0,0,3), "t3_locked");
    step(ST_INIT, 1'b0, 1'b0, ex(0,0,0,0,0,0), "t3_unlock");

    // 4: success clears the count; a later abort does not lock
    step(ST_S1,   1'b0, 1'b0, ex(0,0,0,0,0,0), "t4_s1a");
    step(ST_INIT, 1'b0, 1'b0, ex(0,0,0,0,0,1), "t4_abort1");
    step(ST_S1,   1'b0, 1'b0, ex(0,0,0,0,0,1), "t4_s1b");
    step(ST_INIT, 1'b0, 1'b0, ex(0,0,0,0,0,2), "t4_abort2");
    step(ST_S3,   1'b1, 1'b0, ex(1,0,0,0,0,0), "t4_grant_clr");
    step(ST_INIT, 1'b0, 1'b1, ex(0,0,1,0,0,0), "t4_ack");
    step(ST_INIT, 1'b0, 1'b0, ex(0,0,0,0,0,0), "t4_idle");
    step(ST_S1,   1'b0, 1'b0, ex(0,0,0,0,0,0), "t4_s1c");
    step(ST_INIT, 1'b0, 1'b0, ex(0,0,0,0,0,1), "t4_abort_nolock");
    step(ST_S1,   1'b0, 1'b0, ex(0,0,0,0,0,1), "t5_s1a");
    step(ST_INIT, 1'b0, 1'b0, ex(0,0,0,0,0,2), "t5_abort2");
    step(ST_S1,   1'b0, 1'b0, ex(0,0,0,0,0,2), "t5_s1b");
    step(ST_INIT, 1'b0, 1'b0, ex(0,1,1,1,0,3), "t5_lock");

    // 5: success while locked -> viol only, unlock still after 16 cycles
    step(ST_S3, 1'b1, 1'b0, ex(0,1,1,0,1,3), "t5_viol_succ");
    for (int i = 0; i < 14; i++) step(ST_INIT, 1'b0, 1'b0, ex(0,1,1,0,0,3), "t5_locked");
    step(ST_INIT, 1'b0, 1'b0, ex(0,0,0,0,0,0), "t5_unlock");

    // 6a: illegal state in IDLE locks; illegal at lock cycle 10 extends
    step(3'd7, 1'b0, 1'b0, ex(0,1,1,1,0,0), "t6_ill_lock");
    for (int i = 0; i < 9; i++) step(ST_INIT, 1'b0, 1'b0, ex(0,1,1,0,0,0), "t6_locked_a");
    step(3'd6, 1'b0, 1'b0, ex(0,1,1,0,1,0), "t6_ill_locked");
    for (int i = 0; i < 15; i++) step(ST_INIT, 1'b0, 1'b0, ex(0,1,1,0,0,0), "t6_locked_b");
    step(ST_INIT, 1'b0, 1'b0, ex(0,0,0,0,0,0), "t6_unlock");

    // 6b: async reset mid-GRANTED and mid-LOCKED
    step(ST_S3,   1'b1, 1'b0, ex(1,0,0,0,0,0), "t6_grant");
    step(ST_INIT, 1'b0, 1'b0, ex(1,0,0,0,0,0), "t6_grant2");
    rst_check("t6_rst_granted");
    step(ST_INIT, 1'b0, 1'b0, ex(0,0,0,0,0,0), "t6_post_rst");
    step(ST_S1,   1'b0, 1'b0, ex(0,0,0,0,0,0), "t6_s1a");
    step(ST_INIT, 1'b0, 1'b0, ex(0,0,0,0,0,1), "t6_abort1");
    step(ST_S1,   1'b0, 1'b0, ex(0,0,0,0,0,1), "t6_s1b");
    step(ST_INIT, 1'b0, 1'b0, ex(0,0,0,0,0,2), "t6_abort2");
    step(ST_S1,   1'b0, 1'b0, ex(0,0,0,0,0,2), "t6_s1c");
    step(ST_INIT, 1'b0, 1'b0, ex(0,1,1,1,0,3), "t6_lock");
    step(ST_INIT, 1'b0, 1'b0, ex(0,1,1,0,0,3), "t6_locked_c");
    step(ST_INIT, 1'b0, 1'b0, ex(0,1,1,0,0,3), "t6_locked_d");
    rst_check("t6_rst_locked");
    step(ST_S1,   1'b0, 1'b0, ex(0,0,0,0,0,0), "t6_post_rst2");
    step(ST_INIT, 1'b0, 1'b0, ex(0,0,0,0,0,1), "t6_cnt_restart");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
